jt51_noise_gen: RTL



---
 rtl/jt51_noise_pkg.sv | 27 ++
 rtl/jt51_noise_div.sv | 54 +++++
 rtl/jt51_noise_gen.sv | 122 ++++++++++++
 3 files changed

// File: rtl/jt51_noise_pkg.sv
// Shared constants and helpers for the JT51 noise generator.
// Optional feature macro (consumed by jt51_noise_gen): JT51_NOISE_SEED_EN.
package jt51_noise_pkg;

    localparam int          NOISE_W    = 17;
    localparam int          NOISE_TAPA = 16;
    localparam int          NOISE_TAPB = 13;
    localparam logic [31:0] NOISE_INIT = 32'd14220;
    localparam int          NOISE_FW   = 5;
    localparam int          NOISE_SW   = 8;

    // All-ones mask covering the low w bits of a 32-bit word.
    // The LFSR compares against it to spot the XNOR lock-up state.
    function automatic logic [31:0] noise_ones_mask(input int w);
        logic [31:0] m;
        m = 32'd0;
        for (int i = 0; i < 32; i++) begin
            if (i < w) begin
                m[i] = 1'b1;
            end else begin
                m[i] = 1'b0;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/jt51_noise_div.sv
// Noise frequency divider: counts cen pulses and requests an LFSR shift
// once the count reaches the inverted NFRQ value. The period is
// 2^FW - nfrq cen pulses. A clear input restarts the count (seed load).
module jt51_noise_div
    import jt51_noise_pkg::*;
#(
    parameter int FW = NOISE_FW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen,
    input  logic          en,
    input  logic          clr,
    input  logic [FW-1:0] nfrq,
    output logic          shift
);

    logic [FW-1:0] cnt_r;
    logic [FW-1:0] cnt_nxt_s;
    logic [FW-1:0] lim_s;
    logic          hit_s;

    // Next count and shift request; >= compare so a lowered limit fires at once.
    always_comb begin
        lim_s     = ~nfrq;
        hit_s     = (cnt_r >= lim_s);
        cnt_nxt_s = cnt_r;
        shift     = 1'b0;
        if (cen) begin
            if (clr) begin
                cnt_nxt_s = {FW{1'b0}};
            end else if (!en) begin
                cnt_nxt_s = {FW{1'b0}};
            end else if (hit_s) begin
                cnt_nxt_s = {FW{1'b0}};
                shift     = 1'b1;
            end else begin
                cnt_nxt_s = cnt_r + FW'(1'b1);
            end
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Divider count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {FW{1'b0}};
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end

endmodule

// File: rtl/jt51_noise_gen.sv
// JT51 parametrised noise generator: XNOR LFSR clocked by an NFRQ divider,
// with noise enable, lock-up recovery, a one-cycle step strobe and a
// multi-bit sample word.
// Optional feature: define JT51_NOISE_SEED_EN to add seed_we/seed ports
// that load the LFSR at run time.
module jt51_noise_gen
    import jt51_noise_pkg::*;
#(
    parameter int          W    = NOISE_W,
    parameter int          TAPA = NOISE_TAPA,
    parameter int          TAPB = NOISE_TAPB,
    parameter logic [31:0] INIT = NOISE_INIT,
    parameter int          FW   = NOISE_FW,
    parameter int          SW   = NOISE_SW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen,
    input  logic          en,
    input  logic [FW-1:0] nfrq,
`ifdef JT51_NOISE_SEED_EN
    input  logic          seed_we,
    input  logic [W-1:0]  seed,
`endif
    output logic          step,
    output logic          out,
    output logic [SW-1:0] sample,
    output logic          lock
);

    localparam logic [31:0]  ONES32 = noise_ones_mask(W);
    localparam logic [W-1:0] ONES   = ONES32[W-1:0];
    localparam logic [W-1:0] SEED0  = INIT[W-1:0];

    // Reject parameter sets that would break the LFSR or the output slice.
    if ((W < 4) || (W > 32)) begin : g_bad_w
        $error("jt51_noise_gen: W must be within 4..32");
    end
    if (TAPA != (W - 1)) begin : g_bad_tapa
        $error("jt51_noise_gen: TAPA must equal W-1");
    end
    if (TAPB >= TAPA) begin : g_bad_tapb
        $error("jt51_noise_gen: TAPB must be below TAPA");
    end
    if (SW > W) begin : g_bad_sw
        $error("jt51_noise_gen: SW must not exceed W");
    end
    if (SEED0 == ONES) begin : g_bad_init
        $error("jt51_noise_gen: INIT must not be all-ones");
    end

    // One XNOR LFSR step.
    function automatic logic [W-1:0] lfsr_next(input logic [W-1:0] v);
        return {v[W-2:0], ~(v[TAPA] ^ v[TAPB])};
    endfunction

    logic [W-1:0] bb_r;
    logic [W-1:0] bb_nxt_s;
    logic         step_r;
    logic         lock_r;
    logic         shift_s;
    logic         all_ones_s;
    logic         load_s;
    logic [W-1:0] seed_s;

`ifdef JT51_NOISE_SEED_EN
    assign load_s = cen & seed_we;
    assign seed_s = seed;
`else
    assign load_s = 1'b0;
    assign seed_s = SEED0;
`endif

    jt51_noise_div #(
        .FW (FW)
    ) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .cen   (cen),
        .en    (en),
        .clr   (load_s),
        .nfrq  (nfrq),
        .shift (shift_s)
    );

    assign all_ones_s = (bb_r == ONES);

    // Next LFSR value: seed load beats a shift; all-ones recovers to INIT.
    always_comb begin
        bb_nxt_s = bb_r;
        if (load_s) begin
            bb_nxt_s = seed_s;
        end else if (shift_s) begin
            if (all_ones_s) begin
                bb_nxt_s = SEED0;
            end else begin
                bb_nxt_s = lfsr_next(bb_r);
            end
        end else begin
            bb_nxt_s = bb_r;
        end
    end

    // LFSR state plus step/lock strobes; strobes drop on any edge without a shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bb_r   <= SEED0;
            step_r <= 1'b0;
            lock_r <= 1'b0;
        end else begin
            bb_r   <= bb_nxt_s;
            step_r <= shift_s;
            lock_r <= shift_s & all_ones_s;
        end
    end

    assign step   = step_r;
    assign lock   = lock_r;
    assign out    = bb_r[W-1];
    assign sample = bb_r[W-1 -: SW];

endmodule
